// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter that shares the single L2 request port among NUM_REQ L1 requesters.
// A watchdog turns an L2 transaction that never completes into an error response.
module l2_port_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_accept,
    output logic [NUM_REQ-1:0]               resp_valid,
    output logic [DATA_WIDTH-1:0]            resp_rdata,
    output logic                             resp_error,
    output logic                             l2_read_request,
    output logic                             l2_write_request,
    output logic [ADDRESS_WIDTH-1:0]         l2_addr,
    output logic [DATA_WIDTH-1:0]            l2_wdata,
    input  logic                             l2_ready,
    input  logic [DATA_WIDTH-1:0]            l2_rdata,
    output logic                             busy
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_RESP} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [IDX_W-1:0]         last_grant_q, last_grant_d;
    logic                     write_q, write_d;
    logic                     err_q, err_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [IDX_W-1:0]         winner;
    logic [IDX_W-1:0]         cand;
    logic                     found;

    // Search starts at last_grant+1; the IDX_W-bit sum wraps modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = last_grant_q;
        cand   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = last_grant_q + IDX_W'(i);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        write_d      = write_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d = winner;
                    write_d = req_write[winner];
                    addr_d  = req_addr[int'(winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    wdata_d = req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (l2_ready) begin
                    rdata_d = write_q ? '0 : l2_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                last_grant_d = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        req_accept = '0;
        resp_valid = '0;
        if (state_q == S_GRANT) req_accept[owner_q] = 1'b1;
        if (state_q == S_RESP)  resp_valid[owner_q] = 1'b1;
    end

    assign l2_read_request  = (state_q == S_GRANT || state_q == S_WAIT) && !write_q;
    assign l2_write_request = (state_q == S_GRANT || state_q == S_WAIT) &&  write_q;
    assign l2_addr          = addr_q;
    assign l2_wdata         = wdata_q;
    assign resp_rdata       = rdata_q;
    assign resp_error       = err_q;
    assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Randomized bench for l2_port_arbiter: a transaction-level model predicts grants and responses,
// and an independent monitor pops the expectations when the DUT presents accept/response pulses.
module tb_l2_port_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 64;

    logic               clk = 1'b0;
    logic               reset;
    logic [NR-1:0]      req_valid, req_write, req_accept, resp_valid;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdata;
    logic [DW-1:0]      resp_rdata, l2_wdata, l2_rdata;
    logic               resp_error, l2_read_request, l2_write_request, l2_ready, busy;
    logic [AW-1:0]      l2_addr;

    l2_port_arbiter #(
        .NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_accept(req_accept), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .l2_read_request(l2_read_request),
        .l2_write_request(l2_write_request), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_ready(l2_ready), .l2_rdata(l2_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            idx;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            strobe_end;
        int            resp_cyc;
    } acc_t;

    typedef struct {
        int            cyc;
        int            idx;
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Requester-side state and the transaction-level model.
    logic          v [NR];
    logic          w [NR];
    logic [AW-1:0] a [NR];
    logic [DW-1:0] d [NR];

    logic          m_active = 1'b0;
    int            m_A, m_ready_cyc, m_wait_end, m_resp_cyc, m_owner;
    int            m_last = NR - 1;
    logic [DW-1:0] m_rdata;
    int            ntx = 0;

    int            p_raise, p_drop, p_wd, p_to, force_lat;
    logic          force_to, use_force;
    logic [DW-1:0] force_rdata;

    function automatic int rr_pick(input logic [NR-1:0] vv, input int last);
        int c;
        for (int k = 1; k <= NR; k++) begin
            c = (last + k) % NR;
            if (vv[c]) return c;
        end
        return -1;
    endfunction

    task automatic new_payload(input int i);
        v[i] = 1'b1;
        w[i] = 1'($urandom_range(1));
        a[i] = $urandom;
        d[i] = $urandom;
    endtask

    function automatic logic any_v();
        logic r;
        r = 1'b0;
        for (int i = 0; i < NR; i++) r = r | v[i];
        return r;
    endfunction

    // One cycle of stimulus: n is the cycle whose closing edge will sample what is driven here.
    task automatic body();
        int   n;
        int   lat;
        logic tmo;
        n = cyc;
        if (m_active && n == m_A) begin
            if (int'($urandom_range(99)) < p_drop) v[m_owner] = 1'b0;
            else new_payload(m_owner);
        end
        for (int i = 0; i < NR; i++) begin
            if (v[i] && !(m_active && n == m_A && i == m_owner) && int'($urandom_range(99)) < p_wd)
                v[i] = 1'b0;
            else if (!v[i] && int'($urandom_range(99)) < p_raise)
                new_payload(i);
        end
        if (m_active && n > m_A && n <= m_wait_end) begin
            l2_ready = (n == m_ready_cyc);
            l2_rdata = (n == m_ready_cyc) ? m_rdata : $urandom;
        end else begin
            l2_ready = ($urandom_range(2) == 0);
            l2_rdata = $urandom;
        end
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = v[i];
            req_write[i]          = w[i];
            req_addr[i*AW +: AW]  = a[i];
            req_wdata[i*DW +: DW] = d[i];
        end
        if (!m_active && req_valid != '0) begin
            m_owner  = rr_pick(req_valid, m_last);
            m_active = 1'b1;
            m_A      = n + 1;
            tmo      = force_to || (int'($urandom_range(99)) < p_to);
            force_to = 1'b0;
            if (tmo) begin
                m_ready_cyc = -1;
                m_wait_end  = m_A + TO;
            end else begin
                lat         = (force_lat != 0) ? force_lat : int'($urandom_range(4, 1));
                m_ready_cyc = m_A + lat;
                m_wait_end  = m_ready_cyc;
            end
            m_resp_cyc = m_wait_end + 1;
            m_rdata    = use_force ? force_rdata : $urandom;
            acc_q.push_back('{m_A, m_owner, w[m_owner], a[m_owner], d[m_owner], m_wait_end, m_resp_cyc});
            rsp_q.push_back('{m_resp_cyc, m_owner, (tmo || w[m_owner]) ? '0 : m_rdata, tmo});
            ntx++;
        end else if (m_active && n == m_resp_cyc) begin
            m_active = 1'b0;
            m_last   = m_owner;
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        body();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset    = 1'b1;
        l2_ready = 1'b0;
        m_active = 1'b0;
        m_last   = NR - 1;
        force_to = 1'b0;
        acc_q.delete();
        rsp_q.delete();
        @(negedge clk);
        #1;
        reset = 1'b0;
        body();
    endtask

    task automatic drain();
        p_raise = 0;
        p_drop  = 100;
        p_wd    = 0;
        for (int k = 0; k < 400 && (m_active || any_v()); k++) step();
    endtask

    initial begin : driver
        int base;
        reset     = 1'b1;
        l2_ready  = 1'b0;
        l2_rdata  = '0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NR; i++) begin
            v[i] = 1'b0; w[i] = 1'b0; a[i] = '0; d[i] = '0;
        end
        p_raise = 0; p_drop = 100; p_wd = 0; p_to = 0;
        force_to = 1'b0; force_lat = 0; use_force = 1'b0; force_rdata = '0;

        // Single read from requester 0, L2 ready two cycles after the strobe.
        v[0] = 1'b1; w[0] = 1'b0; a[0] = 32'h0000_1040; d[0] = '0;
        force_lat = 2; use_force = 1'b1; force_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        do_reset();
        repeat (8) step();
        use_force = 1'b0; force_lat = 0;

        // Write from requester 2.
        v[2] = 1'b1; w[2] = 1'b1; a[2] = 32'h4000_0080; d[2] = 32'h1234_5678;
        repeat (10) step();

        // Fairness: all requesters held busy, payloads replaced after each accept.
        for (int i = 0; i < NR; i++) new_payload(i);
        p_drop = 0;
        base   = ntx;
        do_reset();
        for (int k = 0; k < 150 && ntx < base + 8; k++) step();
        drain();

        // Watchdog expiry, then the next requester is served.
        force_to = 1'b1;
        new_payload(1);
        new_payload(2);
        for (int k = 0; k < 5 && force_to; k++) step();
        drain();

        // Reset while the transaction is waiting on L2.
        force_lat = 4;
        for (int i = 0; i < NR; i++) new_payload(i);
        p_drop = 0;
        for (int k = 0; k < 20 && !m_active; k++) step();
        step();
        do_reset();
        force_lat = 0;
        repeat (30) step();

        // Random traffic.
        p_raise = 25; p_drop = 50; p_wd = 2; p_to = 2;
        repeat (700) step();
        p_to = 0;
        drain();
        repeat (3) step();

        chk("scoreboard_empty", 128'(acc_q.size() + rsp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : monitor
        acc_t          cur;
        rsp_t          r;
        logic          cur_v;
        logic          exp_rd, exp_wr;
        logic [NR-1:0] oh;
        int            n;
        cur_v = 1'b0;
        forever begin
            @(negedge clk);
            n = cyc;
            if (reset) begin
                cur_v = 1'b0;
                chk("reset_outputs", {req_accept, resp_valid, resp_rdata, resp_error, l2_read_request,
                                      l2_write_request, l2_addr, l2_wdata, busy}, '0);
            end else begin
                if (req_accept != '0 || (acc_q.size() > 0 && acc_q[0].cyc < n)) begin
                    if (acc_q.size() == 0) begin
                        chk("accept_unexpected", 128'(req_accept), '0);
                    end else begin
                        cur   = acc_q.pop_front();
                        cur_v = 1'b1;
                        oh    = '0;
                        oh[cur.idx] = 1'b1;
                        chk("accept_index", 128'(req_accept), 128'(oh));
                        chk("accept_cycle", 128'(n), 128'(cur.cyc));
                    end
                end
                exp_rd = cur_v && n >= cur.cyc && n <= cur.strobe_end && !cur.write;
                exp_wr = cur_v && n >= cur.cyc && n <= cur.strobe_end &&  cur.write;
                chk("l2_strobes", {l2_read_request, l2_write_request}, {exp_rd, exp_wr});
                if (exp_rd || exp_wr) begin
                    chk("l2_addr", 128'(l2_addr), 128'(cur.addr));
                    chk("l2_wdata", 128'(l2_wdata), 128'(cur.wdata));
                end
                chk("busy", busy, cur_v && n <= cur.resp_cyc);
                if (resp_valid != '0 || (rsp_q.size() > 0 && rsp_q[0].cyc < n)) begin
                    if (rsp_q.size() == 0) begin
                        chk("resp_unexpected", 128'(resp_valid), '0);
                    end else begin
                        r  = rsp_q.pop_front();
                        oh = '0;
                        oh[r.idx] = 1'b1;
                        chk("resp_owner", 128'(resp_valid), 128'(oh));
                        chk("resp_cycle", 128'(n), 128'(r.cyc));
                        chk("resp_rdata", 128'(resp_rdata), 128'(r.rdata));
                        chk("resp_error", resp_error, r.err);
                    end
                end
                if (cur_v && n >= cur.resp_cyc) cur_v = 1'b0;
            end
        end
    end

endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Round-robin arbiter and sequencer that shares the single request port of the L2 cache controller among `NUM_REQ` L1 requesters (one per processor ID). It captures one request at a time and drives the L2 read/write strobes until the L2 reports ready. It then returns the result to the owning requester and advances fairness to the next requester. A watchdog converts a hung L2 transaction into an error response, so no requester can stall indefinitely.

## Interface
- `NUM_REQ`, 4, number of L1 requesters (power of two, 2..8)
- `ADDRESS_WIDTH`, 32, request address width
- `DATA_WIDTH`, 32, word width
- `TIMEOUT`, 64, max cycles to wait for `l2_ready` (≥2)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  NUM_REQ  per-requester request pending
- `req_write`  in  NUM_REQ  1=write, 0=read
- `req_addr`  in  NUM_REQ*ADDRESS_WIDTH  packed, requester i at slice i
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data
- `req_accept`  out  NUM_REQ  one-cycle pulse: request i captured
- `resp_valid`  out  NUM_REQ  one-cycle pulse: response for requester i
- `resp_rdata`  out  DATA_WIDTH  read data, valid with `resp_valid`
- `resp_error`  out  1  timeout flag, valid with `resp_valid`
- `l2_read_request`  out  1  read strobe to L2, held until `l2_ready`
- `l2_write_request`  out  1  write strobe to L2, held until `l2_ready`
- `l2_addr`  out  ADDRESS_WIDTH  captured address
- `l2_wdata`  out  DATA_WIDTH  captured write data
- `l2_ready`  in  1  L2 transaction complete
- `l2_rdata`  in  DATA_WIDTH  L2 read data, valid with `l2_ready`
- `busy`  out  1  high in every state except IDLE

## Operation
- The state machine has four states: IDLE, GRANT, WAIT and RESP.
- IDLE, any `req_valid` set:
  - Select the winner by round-robin search starting at `last_grant+1` modulo NUM_REQ.
  - Capture the winner's addr, wdata, write bit and index into owner registers.
  - Go to GRANT.
- IDLE, no `req_valid` set: stay in IDLE.
- GRANT (1 cycle):
  - Pulse `req_accept[owner]`.
  - Assert `l2_read_request` or `l2_write_request` per the captured write bit.
  - Clear the timeout counter.
  - Go to WAIT.
- WAIT:
  - Hold the strobe, `l2_addr` and `l2_wdata` stable.
  - Increment the counter each cycle.
  - If `l2_ready`=1: capture `l2_rdata` (write: capture 0), set err=0, go to RESP.
  - Else if counter reaches TIMEOUT-1: set err=1, rdata=0, go to RESP.
- RESP (1 cycle):
  - Deassert strobes.
  - Pulse `resp_valid[owner]` with `resp_rdata`/`resp_error`.
  - Set `last_grant`=owner.
  - Go to IDLE.
- Fairness: a continuously requesting agent waits at most NUM_REQ-1 other transactions.
- Requesters hold `req_valid` and payload stable until `req_accept`.
  - Changes after capture (at the IDLE→GRANT edge) are ignored for the current transaction.
  - A requester deasserting `req_valid` before capture is simply not selected.
- Exactly one strobe is high at a time; both are low outside GRANT/WAIT.
- `l2_ready` outside WAIT (including in GRANT) is ignored.

## Timing
- Reset values of outputs and registers:
  - state=IDLE, `last_grant`=NUM_REQ-1 (so requester 0 is first priority).
  - All outputs 0: `req_accept`, `resp_valid`, `resp_rdata`, `resp_error`, both strobes, `l2_addr`, `l2_wdata`, `busy`.
- All outputs are registered/state-decoded; there are no combinational paths from inputs to outputs.
- Latency, with `req_valid` seen in IDLE at edge 0:
  - State enters GRANT after edge 0: `req_accept` and strobe high in cycle 1.
  - Earliest `l2_ready` is sampled at edge 2 (in WAIT).
  - `resp_valid` is high in cycle 3.
  - Minimum request-to-response is 3 cycles; throughput is one transaction per 4 cycles minimum.
- Timeout: with no `l2_ready`, `resp_valid` with `resp_error`=1 fires TIMEOUT+1 cycles after `req_accept`.
- Back-to-back: IDLE is occupied for one cycle between transactions; new requests arriving during a transaction wait for IDLE.
- Reset mid-transaction:
  - Return immediately to the reset state and drop strobes.
  - No `resp_valid` is issued; requesters re-request.

## Test plan
- Single read: `req_valid`=0001, addr 0x0000_1040; L2 returns `l2_ready` with rdata 0xDEADBEEF 2 cycles after strobe → `req_accept`[0] in cycle 1, `l2_read_request` high cycles 1–3, `resp_valid`[0] with 0xDEADBEEF, err 0.
- Write: requester 2 writes 0x1234_5678 to 0x4000_0080 → `l2_write_request` only, `l2_wdata`=0x12345678, `resp_valid`[2], rdata 0.
- Fairness: all four `req_valid` held high for 8 transactions after reset → grant order 0,1,2,3,0,1,2,3.
- Timeout: TIMEOUT=64, `l2_ready` never asserted → `resp_valid` with `resp_error`=1 exactly 65 cycles after `req_accept`, then the next requester is served.
- Reset during WAIT: assert reset mid-transaction → all strobes 0 next cycle, no `resp_valid`, and after release requester 0 has priority.
- Spurious `l2_ready` in IDLE/GRANT and payload change after accept → ignored; `l2_addr` stays at the captured value.
